// File: rtl/mips_multicycle_ctrl_if.sv
// rtl/mips_multicycle_ctrl_if.sv - control/datapath bundle for the multicycle MIPS controller
interface mips_multicycle_ctrl_if #(
    parameter int COUNT_W = 16
);
    logic               instr_valid;
    logic               instr_ready;
    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic               alu_zero;
    logic               mem_ready;
    logic               ir_write;
    logic               pc_write;
    logic [1:0]         pc_src;
    logic [2:0]         alu_ctrl;
    logic               alu_src_b;
    logic               reg_write;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic               mem_read;
    logic               mem_write;
    logic [2:0]         state;
    logic [COUNT_W-1:0] retired;
    logic               trap;
    logic [1:0]         trap_cause;

    modport master (
        input  instr_valid, opcode, funct, alu_zero, mem_ready,
        output instr_ready, ir_write, pc_write, pc_src, alu_ctrl, alu_src_b,
               reg_write, reg_dst, mem_to_reg, mem_read, mem_write,
               state, retired, trap, trap_cause
    );

    modport slave (
        output instr_valid, opcode, funct, alu_zero, mem_ready,
        input  instr_ready, ir_write, pc_write, pc_src, alu_ctrl, alu_src_b,
               reg_write, reg_dst, mem_to_reg, mem_read, mem_write,
               state, retired, trap, trap_cause
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS control FSM with retire counter and trap
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int COUNT_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [5:0]         op_q, fn_q;
    logic [7:0]         tmo_q;
    logic [COUNT_W-1:0] ret_q;
    logic               trap_q;
    logic [1:0]         cause_q, cause_d;
    logic               retire;

    logic       instr_ready, ir_write, pc_write, alu_src_b, reg_write, mem_read, mem_write;
    logic [1:0] pc_src, reg_dst, mem_to_reg;
    logic [2:0] alu_ctrl;

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_R)
            return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
                   (fn == FN_OR)  || (fn == FN_SLT) || (fn == FN_JR);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_J)  || (op == OP_JAL) || (op == OP_ADDI);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= 6'd0;
            fn_q    <= 6'd0;
            tmo_q   <= 8'd0;
            ret_q   <= '0;
            trap_q  <= 1'b0;
            cause_q <= 2'd0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            trap_q  <= (state_d == S_TRAP);
            if (state_q == S_DECODE) begin
                op_q <= bus.opcode;
                fn_q <= bus.funct;
            end
            // Cleared whenever outside MEM, so each MEM visit starts counting from zero.
            tmo_q <= (state_q == S_MEM) ? tmo_q + 8'd1 : 8'd0;
            if (retire)
                ret_q <= ret_q + COUNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        retire      = 1'b0;
        instr_ready = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 2'd0;
        alu_ctrl    = 3'b000;
        alu_src_b   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'd0;
        mem_to_reg  = 2'd0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_legal(bus.opcode, bus.funct)) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    cause_d = 2'd1;
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_R: begin
                        if (fn_q == FN_JR) begin
                            pc_src   = 2'd3;
                            pc_write = 1'b1;
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                        end else begin
                            case (fn_q)
                                FN_SUB:  alu_ctrl = 3'b110;
                                FN_AND:  alu_ctrl = 3'b000;
                                FN_OR:   alu_ctrl = 3'b001;
                                FN_SLT:  alu_ctrl = 3'b111;
                                default: alu_ctrl = 3'b010;
                            endcase
                            state_d = S_WB;
                        end
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        alu_ctrl  = 3'b010;
                        alu_src_b = 1'b1;
                        state_d   = (op_q == OP_ADDI) ? S_WB : S_MEM;
                    end
                    OP_BEQ: begin
                        alu_ctrl = 3'b110;
                        pc_src   = 2'd1;
                        pc_write = bus.alu_zero;
                        retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_J, OP_JAL: begin
                        pc_src   = 2'd2;
                        pc_write = 1'b1;
                        if (op_q == OP_JAL) begin
                            reg_write  = 1'b1;
                            reg_dst    = 2'd2;
                            mem_to_reg = 2'd2;
                        end
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        state_d = S_TRAP;
                        cause_d = 2'd1;
                    end
                endcase
            end
            S_MEM: begin
                mem_read  = (op_q == OP_LW);
                mem_write = (op_q != OP_LW);
                if (bus.mem_ready) begin
                    if (op_q == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_TRAP;
                    cause_d = 2'd2;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op_q == OP_R) ? 2'd1 : 2'd0;
                mem_to_reg = (op_q == OP_LW) ? 2'd1 : 2'd0;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_TRAP;
        endcase

        // Reset is synchronous, so the state register still holds the old state this cycle.
        if (reset) begin
            instr_ready = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            pc_src      = 2'd0;
            alu_ctrl    = 3'b000;
            alu_src_b   = 1'b0;
            reg_write   = 1'b0;
            reg_dst     = 2'd0;
            mem_to_reg  = 2'd0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
        end
    end

    assign bus.instr_ready = instr_ready;
    assign bus.ir_write    = ir_write;
    assign bus.pc_write    = pc_write;
    assign bus.pc_src      = pc_src;
    assign bus.alu_ctrl    = alu_ctrl;
    assign bus.alu_src_b   = alu_src_b;
    assign bus.reg_write   = reg_write;
    assign bus.reg_dst     = reg_dst;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.state       = state_q;
    assign bus.retired     = ret_q;
    assign bus.trap        = trap_q;
    assign bus.trap_cause  = cause_q;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
    localparam int CW  = 4;
    localparam int TMO = 15;

    localparam int K_RALU = 0, K_JR = 1, K_LW = 2, K_SW = 3, K_BEQ = 4,
                   K_J = 5, K_JAL = 6, K_ADDI = 7, K_ILL = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if #(.COUNT_W(CW)) bus ();
    mips_multicycle_ctrl #(.MEM_TIMEOUT(TMO), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ret = 0;

    wire [18:0] obs = {bus.state, bus.instr_ready, bus.ir_write, bus.pc_write, bus.pc_src,
                       bus.alu_ctrl, bus.alu_src_b, bus.reg_write, bus.reg_dst,
                       bus.mem_to_reg, bus.mem_read, bus.mem_write};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [18:0] e(input int st, input int rdy, input int iw, input int pw,
                                      input int ps, input int ac, input int asb, input int rw,
                                      input int rd, input int mtr, input int mr, input int mw);
        return {3'(st), 1'(rdy), 1'(iw), 1'(pw), 2'(ps), 3'(ac), 1'(asb), 1'(rw),
                2'(rd), 2'(mtr), 1'(mr), 1'(mw)};
    endfunction

    function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) begin
            case (fn)
                6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return K_RALU;
                6'b001000: return K_JR;
                default:   return K_ILL;
            endcase
        end
        case (op)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b000010: return K_J;
            6'b000011: return K_JAL;
            6'b001000: return K_ADDI;
            default:   return K_ILL;
        endcase
    endfunction

    function automatic int alu_of(input logic [5:0] fn);
        case (fn)
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b101010: return 7;
            default:   return 2;
        endcase
    endfunction

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic logic r1();
        return 1'($urandom);
    endfunction

    // One clock cycle: drive inputs just after the edge, compare mid-cycle.
    task automatic cyc(input string tag, input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic z, input logic mr, input logic [18:0] want);
        bus.instr_valid = v;
        bus.opcode      = op;
        bus.funct       = fn;
        bus.alu_zero    = z;
        bus.mem_ready   = mr;
        #3;
        check(tag, 32'(obs), 32'(want));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.instr_valid = r1();
        bus.alu_zero    = r1();
        bus.mem_ready   = r1();
        reset = 1'b1;
        #3;
        check("reset_strobes", 32'(obs[15:0]), 32'd0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_ret = 0;
        check("reset_retired", 32'(bus.retired), 32'd0);
        check("reset_trap", {30'd0, bus.trap, 1'b0}, 32'd0);
        check("reset_cause", 32'(bus.trap_cause), 32'd0);
        cyc("idle", r1(), r6(), r6(), r1(), r1(), e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic trap_tail(input int cause);
        for (int i = 0; i < 3; i++)
            cyc("trap_state", 1'b1, r6(), r6(), r1(), r1(), e(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("trap_flag", 32'(bus.trap), 32'd1);
        check("trap_cause", 32'(bus.trap_cause), 32'(cause));
        check("trap_retired", 32'(bus.retired), 32'(exp_ret));
    endtask

    // ready_at: MEM cycle (1-based) on which mem_ready is raised; 0 = never.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int ready_at, input int vdelay, output bit trapped);
        int k;
        logic [18:0] ex;
        bit done;
        k = kind(op, fn);
        trapped = 1'b0;
        for (int i = 0; i < vdelay; i++)
            cyc("fetch_wait", 1'b0, r6(), r6(), r1(), r1(), e(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("fetch", 1'b1, r6(), r6(), r1(), r1(), e(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("decode", r1(), op, fn, r1(), r1(), e(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (k == K_ILL) begin
            trap_tail(1);
            trapped = 1'b1;
            return;
        end
        case (k)
            K_RALU:               ex = e(3, 0, 0, 0, 0, alu_of(fn), 0, 0, 0, 0, 0, 0);
            K_JR:                 ex = e(3, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0);
            K_BEQ:                ex = e(3, 0, 0, int'(z), 1, 6, 0, 0, 0, 0, 0, 0);
            K_J:                  ex = e(3, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0);
            K_JAL:                ex = e(3, 0, 0, 1, 2, 0, 0, 1, 2, 2, 0, 0);
            default:              ex = e(3, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0);
        endcase
        cyc("exec", r1(), r6(), r6(), z, r1(), ex);
        if (k == K_LW || k == K_SW) begin
            done = 1'b0;
            for (int m = 1; m <= TMO && !done; m++) begin
                done = (m == ready_at);
                cyc("mem", r1(), r6(), r6(), r1(), done,
                    e(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, int'(k == K_LW), int'(k == K_SW)));
            end
            if (!done) begin
                trap_tail(2);
                trapped = 1'b1;
                return;
            end
        end
        if (k == K_RALU || k == K_ADDI || k == K_LW)
            cyc("wb", r1(), r6(), r6(), r1(), r1(),
                e(5, 0, 0, 0, 0, 0, 0, 1, int'(k == K_RALU), int'(k == K_LW), 0, 0));
        exp_ret = (exp_ret + 1) % (1 << CW);
        check("retired", 32'(bus.retired), 32'(exp_ret));
        check("back_to_fetch", 32'(bus.state), 32'd1);
    endtask

    logic [5:0] legal_op [10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03};
    logic [5:0] legal_fn [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    initial begin
        bit tr;
        int idx, ra;
        logic [5:0] op, fn;
        reset = 1'b1;
        bus.instr_valid = 1'b0;
        bus.opcode      = 6'd0;
        bus.funct       = 6'd0;
        bus.alu_zero    = 1'b0;
        bus.mem_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        run_instr(6'b000000, 6'b100000, 1'b0, 0, 5, tr);     // add after idle fetch
        run_instr(6'b100011, r6(), 1'b0, 3, 0, tr);          // lw, ready on 3rd MEM cycle
        run_instr(6'b101011, r6(), 1'b0, 0, 0, tr);          // sw, timeout trap
        check("sw_timeout_trapped", 32'(tr), 32'd1);
        do_reset();
        run_instr(6'b000100, r6(), 1'b1, 0, 0, tr);          // beq taken
        run_instr(6'b000100, r6(), 1'b0, 0, 1, tr);          // beq not taken
        run_instr(6'b000000, 6'b001000, 1'b0, 0, 0, tr);     // jr
        run_instr(6'b001000, r6(), 1'b0, 0, 0, tr);          // addi
        run_instr(6'b110000, r6(), 1'b0, 0, 0, tr);          // illegal opcode
        do_reset();
        run_instr(6'b000000, 6'b000001, 1'b0, 0, 0, tr);     // illegal funct
        do_reset();
        run_instr(6'b000011, r6(), 1'b0, 0, 0, tr);          // jal
        run_instr(6'b100011, r6(), 1'b0, TMO, 0, tr);        // lw ready on last allowed cycle
        run_instr(6'b101011, r6(), 1'b0, 1, 0, tr);          // sw immediate ready

        // Reset while the lw is in EXEC abandons it.
        cyc("fetch_abort", 1'b1, r6(), r6(), 1'b0, 1'b0, e(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc("decode_abort", 1'b0, 6'b100011, r6(), 1'b0, 1'b0, e(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        do_reset();

        for (int i = 0; i < (1 << CW); i++)
            run_instr(6'b000010, r6(), r1(), 0, 0, tr);
        check("retired_wrap", 32'(bus.retired), 32'd0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = r6();
                fn = r6();
            end else begin
                idx = $urandom_range(0, 9);
                op = (idx == 9 && r1()) ? 6'b001000 : legal_op[idx];
                fn = (op == 6'b000000 && idx == 9) ? 6'b001000 : legal_fn[idx];
                if (op != 6'b000000) fn = r6();
            end
            ra = $urandom_range(0, 17);
            if (ra > TMO) ra = 0;
            run_instr(op, fn, r1(), ra, $urandom_range(0, 2), tr);
            if (tr) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
